// File: rtl/seq_match_counter.sv
// seq_match_counter: counts one-cycle match strobes over consecutive
// programmable windows and publishes each window's count on a
// valid/ready report port with overwrite detection.
// Optional feature macro: MATCH_IRQ_EN (adds thresh input and irq output).
module seq_match_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic             match_in,
`ifdef MATCH_IRQ_EN
    input  logic [CNT_W-1:0] thresh,
    output logic             irq,
`endif
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_lost
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    // Saturating increment: returns {overflow, next_value}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W:0] r;
        if (inc && (v == CNT_MAX)) begin
            r = {1'b1, CNT_MAX};
        end else if (inc) begin
            r = {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

    state_t           state, state_nx;
    logic [WIN_W-1:0] win_rem, win_rem_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sat, sat_nx;
    logic [CNT_W:0]   inc_res;
    logic             rpt_load;
    logic [CNT_W-1:0] ld_count;
    logic             ld_sat;
`ifdef MATCH_IRQ_EN
    logic             irq_nx;
    logic             thr_hit;
`endif

    assign inc_res = sat_inc(cnt, match_in);

`ifdef MATCH_IRQ_EN
    // The count only rises, so "becomes equal" is a real increment landing on thresh.
    assign thr_hit = match_in && !inc_res[CNT_W] && (thresh != '0)
                     && (inc_res[CNT_W-1:0] == thresh);
`endif

    // Next-state, window bookkeeping and report-load decision.
    always_comb begin
        state_nx   = state;
        win_rem_nx = win_rem;
        cnt_nx     = cnt;
        sat_nx     = sat;
        rpt_load   = 1'b0;
        ld_count   = inc_res[CNT_W-1:0];
        ld_sat     = sat | inc_res[CNT_W];
`ifdef MATCH_IRQ_EN
        irq_nx     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (enable && (window_len != '0)) begin
                    state_nx   = COUNT;
                    win_rem_nx = window_len;
                    cnt_nx     = '0;
                    sat_nx     = 1'b0;
                end
            end
            COUNT: begin
                if (win_rem == WIN_ONE) begin
                    // Last window cycle: report includes this cycle's match.
                    rpt_load = 1'b1;
`ifdef MATCH_IRQ_EN
                    irq_nx   = thr_hit;
`endif
                    cnt_nx   = '0;
                    sat_nx   = 1'b0;
                    if (enable && (window_len != '0)) begin
                        win_rem_nx = window_len;
                    end else begin
                        state_nx   = IDLE;
                        win_rem_nx = '0;
                    end
                end else if (!enable) begin
                    // Abort: partial count is discarded without a report.
                    state_nx   = IDLE;
                    win_rem_nx = '0;
                    cnt_nx     = '0;
                    sat_nx     = 1'b0;
                end else begin
                    cnt_nx     = inc_res[CNT_W-1:0];
                    sat_nx     = sat | inc_res[CNT_W];
                    win_rem_nx = win_rem - WIN_ONE;
`ifdef MATCH_IRQ_EN
                    irq_nx     = thr_hit;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Window down-counter, match counter and saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_rem <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
        end else begin
            win_rem <= win_rem_nx;
            cnt     <= cnt_nx;
            sat     <= sat_nx;
        end
    end

    // Report register with handshake; a load while unaccepted marks the loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_valid <= 1'b0;
            rpt_count <= '0;
            rpt_sat   <= 1'b0;
            rpt_lost  <= 1'b0;
        end else if (rpt_load) begin
            rpt_valid <= 1'b1;
            rpt_count <= ld_count;
            rpt_sat   <= ld_sat;
            if (rpt_valid && !rpt_ready) begin
                rpt_lost <= 1'b1;
            end
        end else if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

`ifdef MATCH_IRQ_EN
    // Registered one-cycle threshold pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_nx;
        end
    end
`endif

endmodule

// File: tb/tb_seq_match_counter.sv
// Bench for seq_match_counter: directed scenarios plus randomized windows,
// each compared cycle by cycle against a window-sum reference model.
module tb_seq_match_counter;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIN_W-1:0] window_len;
    logic             match_in;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             rpt_lost;
`ifdef MATCH_IRQ_EN
    logic [CNT_W-1:0] thresh;
    logic             irq;
`endif

    int tests = 0;
    int fails = 0;

    // Stimulus tables: m_arr[s] is the match for window sample s,
    // r_arr[e-1] is rpt_ready presented at edge e of a run.
    bit m_arr [0:1023];
    bit r_arr [0:1023];

    // Model of the report port.
    bit ev, es, el;
    int ec;
    int irq_seen;

    seq_match_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .window_len(window_len),
        .match_in(match_in),
`ifdef MATCH_IRQ_EN
        .thresh(thresh),
        .irq(irq),
`endif
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_count(rpt_count),
        .rpt_sat(rpt_sat),
        .rpt_lost(rpt_lost)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; match_in = 1'b0; rpt_ready = 1'b0;
        window_len = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        ev = 0; es = 0; el = 0; ec = 0;
    endtask

    // Runs nwin back-to-back windows of length n from IDLE, enable dropping
    // on the last sample so the final window still reports, then tail cycles.
    task automatic run_seq(input string name, input int n, input int nwin, input int tail);
        int  e_total;
        int  s;
        int  wsum;
        bit  ld;
        bit  r_prev;
        bit  e_irq;
        int  ncount;
        bit  nsat;
        e_total = 1 + nwin * n + tail;
        wsum = 0;
        enable = 1'b1; window_len = WIN_W'(n); match_in = 1'b0; rpt_ready = r_arr[0];
        for (int e = 1; e <= e_total; e++) begin
            r_prev = rpt_ready;
            @(posedge clk); #1;
            s = e - 2;
            ld = 0; e_irq = 0; ncount = 0; nsat = 0;
            if (s >= 0 && s < nwin * n) begin
                if (s % n == 0) wsum = 0;
`ifdef MATCH_IRQ_EN
                if (m_arr[s] && thresh != 0 && wsum + 1 == int'(thresh)) e_irq = 1;
`endif
                wsum += int'(m_arr[s]);
                if (s % n == n - 1) begin
                    ld = 1;
                    ncount = (wsum > MAXC) ? MAXC : wsum;
                    nsat = (wsum > MAXC);
                end
            end
            if (ld) begin
                if (ev && !r_prev) el = 1;
                ev = 1; ec = ncount; es = nsat;
            end else if (ev && r_prev) begin
                ev = 0;
            end
            tests++;
            if (rpt_valid !== ev) begin
                fails++;
                $display("FAIL %s valid edge %0d: got %b want %b", name, e, rpt_valid, ev);
            end
            if (ev) begin
                tests++;
                if (rpt_count !== CNT_W'(ec) || rpt_sat !== es) begin
                    fails++;
                    $display("FAIL %s data edge %0d: got %0d/%b want %0d/%b",
                             name, e, rpt_count, rpt_sat, ec, es);
                end
            end
            tests++;
            if (rpt_lost !== el) begin
                fails++;
                $display("FAIL %s lost edge %0d: got %b want %b", name, e, rpt_lost, el);
            end
`ifdef MATCH_IRQ_EN
            if (irq === 1'b1) irq_seen++;
            tests++;
            if (irq !== e_irq) begin
                fails++;
                $display("FAIL %s irq edge %0d: got %b want %b", name, e, irq, e_irq);
            end
`endif
            match_in  = (e - 1 < nwin * n) ? m_arr[e - 1] : 1'b0;
            enable    = (e + 1 < 1 + nwin * n);
            rpt_ready = r_arr[e];
        end
        enable = 1'b0; match_in = 1'b0;
    endtask

    task automatic clear_tables(input bit rdy);
        for (int i = 0; i < 1024; i++) begin
            m_arr[i] = 1'b0;
            r_arr[i] = rdy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; window_len = 16'd5; match_in = 1'b1; rpt_ready = 1'b0;
`ifdef MATCH_IRQ_EN
        thresh = 8'd1;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if ({rpt_valid, rpt_count, rpt_sat, rpt_lost} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b c=%0d s=%b l=%b want all 0",
                     rpt_valid, rpt_count, rpt_sat, rpt_lost);
        end
`ifdef MATCH_IRQ_EN
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        thresh = '0;
`endif
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        clear_tables(1'b1);
        m_arr[2] = 1; m_arr[5] = 1; m_arr[9] = 1;
        run_seq("basic", 10, 1, 4);
    endtask

    task automatic test_saturation();
        do_reset();
        clear_tables(1'b1);
        for (int i = 0; i < 300; i++) m_arr[i] = 1'b1;
        run_seq("saturation", 300, 1, 0);
        tests++;
        if (rpt_valid !== 1'b1 || rpt_count !== 8'd255 || rpt_sat !== 1'b1) begin
            fails++;
            $display("FAIL saturation_report: got v=%b c=%0d s=%b want 1/255/1",
                     rpt_valid, rpt_count, rpt_sat);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_tables(1'b0);
        m_arr[1] = 1;
        m_arr[4] = 1; m_arr[6] = 1;
        // Ready rises only after the second report (edge 9), at edge 10.
        r_arr[9] = 1'b1; r_arr[10] = 1'b1; r_arr[11] = 1'b1;
        run_seq("backpressure", 4, 2, 0);
        tests++;
        if (rpt_count !== 8'd2 || rpt_lost !== 1'b1 || rpt_valid !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_second: got c=%0d l=%b v=%b want 2/1/1",
                     rpt_count, rpt_lost, rpt_valid);
        end
        rpt_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rpt_valid !== 1'b0 || rpt_lost !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_drain: got v=%b l=%b want 0/1", rpt_valid, rpt_lost);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_tables(1'b0);
        m_arr[0] = 1; m_arr[5] = 1; m_arr[6] = 1; m_arr[7] = 1;
        r_arr[8] = 1'b1;  // ready only on the edge loading the second report
        run_seq("simul_accept", 4, 2, 3);
        tests++;
        if (rpt_valid !== 1'b1 || rpt_count !== 8'd3 || rpt_lost !== 1'b0) begin
            fails++;
            $display("FAIL simul_accept_final: got v=%b c=%0d l=%b want 1/3/0",
                     rpt_valid, rpt_count, rpt_lost);
        end
    endtask

    task automatic test_abort_reset();
        int vseen;
        do_reset();
        rpt_ready = 1'b1;
        enable = 1'b1; window_len = 16'd8; match_in = 1'b0;
        @(posedge clk); #1;
        vseen = 0;
        for (int i = 0; i < 20; i++) begin
            match_in = 1'b1;
            if (i >= 3) enable = 1'b0;
            @(posedge clk); #1;
            if (rpt_valid) vseen++;
        end
        tests++;
        if (vseen != 0) begin
            fails++;
            $display("FAIL abort_no_report: got %0d valid cycles want 0", vseen);
        end
        // Reset mid-window while an unaccepted report is pending.
        do_reset();
        clear_tables(1'b0);
        m_arr[1] = 1;
        run_seq("pre_reset", 3, 1, 1);
        enable = 1'b1; window_len = 16'd6; match_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (rpt_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_precondition: got v=%b want 1", rpt_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b0;
        tests++;
        if ({rpt_valid, rpt_count, rpt_sat, rpt_lost} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got v=%b c=%0d s=%b l=%b want all 0",
                     rpt_valid, rpt_count, rpt_sat, rpt_lost);
        end
        ev = 0; es = 0; el = 0; ec = 0;
        // From IDLE a fresh window must report exactly on schedule.
        clear_tables(1'b1);
        m_arr[0] = 1; m_arr[4] = 1;
        run_seq("after_reset", 5, 1, 2);
    endtask

`ifdef MATCH_IRQ_EN
    task automatic test_irq();
        do_reset();
        clear_tables(1'b1);
        thresh = 8'd2;
        m_arr[1] = 1; m_arr[3] = 1; m_arr[6] = 1;
        irq_seen = 0;
        run_seq("irq_thresh2", 8, 1, 2);
        tests++;
        if (irq_seen != 1) begin
            fails++;
            $display("FAIL irq_single_pulse: got %0d pulses want 1", irq_seen);
        end
        thresh = 8'd0;
        irq_seen = 0;
        run_seq("irq_thresh0", 8, 1, 2);
        tests++;
        if (irq_seen != 0) begin
            fails++;
            $display("FAIL irq_thresh_zero: got %0d pulses want 0", irq_seen);
        end
    endtask
`endif

    task automatic test_random();
        int n, nw, p, rp;
        for (int t = 0; t < 12; t++) begin
            do_reset();
            n  = $urandom_range(1, 12);
            nw = $urandom_range(1, 6);
            p  = $urandom_range(10, 90);
            rp = $urandom_range(0, 100);
`ifdef MATCH_IRQ_EN
            thresh = CNT_W'($urandom_range(0, 6));
`endif
            for (int i = 0; i < 1024; i++) begin
                m_arr[i] = ($urandom_range(0, 99) < p);
                r_arr[i] = ($urandom_range(0, 99) < rp);
            end
            run_seq("random", n, nw, 6);
        end
    endtask

    initial begin
        irq_seen = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_abort_reset();
`ifdef MATCH_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
